cc_collision_detector: RTL and testbench
========================================

# cc_collision_detector

Frame-based collision arbiter for the Frogger playfield; the parametrised successor to the single-row combinational frog/background compare. It consumes the playfield one row per strobe, ORs frog-and-background overlaps across a whole frame, requires the overlap to persist for a configurable number of consecutive frames, and manages lives, post-hit grace frames and a sticky game-over. It sits between the scan/matrix logic and the game-control FSM, which reads its lose, hit and lives outputs.

## Interface
- DATAWIDTH, 8, bits per playfield row
- ROWS, 8, rows per frame; row index width RW = max(1, clog2(ROWS))
- HIT_FRAMES, 2, consecutive colliding frames required to register a hit (>=1)
- GRACE_FRAMES, 16, frames of collision immunity after a non-fatal hit (>=0)
- LIVES, 3, lives loaded at reset/restart (>=1); lives width LW = clog2(LIVES+1)

- CC_COLLISIONDETECTOR_CLOCK_50  in  1  system clock, all logic on rising edge
- CC_COLLISIONDETECTOR_RESET_InHigh  in  1  synchronous, active-high reset
- CC_COLLISIONDETECTOR_frameStart_In  in  1  one-cycle pulse, opens a frame
- CC_COLLISIONDETECTOR_frameEnd_In  in  1  one-cycle pulse, closes and evaluates a frame
- CC_COLLISIONDETECTOR_rowValid_In  in  1  current row buses are valid
- CC_COLLISIONDETECTOR_rowIndex_In  in  RW  index of current row
- CC_COLLISIONDETECTOR_backgBUS  in  DATAWIDTH  background (cars/obstacles) row bits
- CC_COLLISIONDETECTOR_froggerBUS  in  DATAWIDTH  frog row bits
- CC_COLLISIONDETECTOR_restart_In  in  1  reload lives, leave game-over
- CC_COLLISIONDETECTOR_lose_OutLow  out  1  0 = game over (sticky), 1 = playing
- CC_COLLISIONDETECTOR_hit_Out  out  1  one-cycle pulse per registered hit
- CC_COLLISIONDETECTOR_lives_Out  out  LW  remaining lives
- CC_COLLISIONDETECTOR_grace_Out  out  1  1 while in GRACE

## Operation
- Row hit = rowValid & (rowIndex < ROWS) & |(froggerBUS & backgBUS); rows with index >= ROWS ignored.
- Frame accumulator: cleared on frameStart; ORs row hits. frameStart and rowValid same cycle: row counts toward new frame. frameEnd and rowValid same cycle: row included in evaluation. frameStart and frameEnd same cycle: evaluation uses only that cycle's row hit, accumulator then cleared.
- States: PLAY, GRACE, GAMEOVER. Streak counter saturates at HIT_FRAMES.
- PLAY, frameEnd: frame hit -> streak+1; on reaching HIT_FRAMES: hit pulse, lives-1, streak=0; lives now 0 -> GAMEOVER; else GRACE_FRAMES>0 -> GRACE with grace count = GRACE_FRAMES; else stay PLAY. No frame hit -> streak=0.
- GRACE, frameEnd: collisions ignored, streak held 0, grace count -1; reaching 0 -> PLAY.
- GAMEOVER: lose_OutLow=0, frames ignored, lives=0.
- restart (any state) has priority over frameEnd: state PLAY, lives=LIVES, streak=0, grace count=0, accumulator cleared, no hit pulse.
- Without frameEnd, state, streak and lives never change.

## Timing
- All outputs registered. Reset values: lose_OutLow=1, hit_Out=0, lives_Out=LIVES, grace_Out=0; state PLAY, streak 0, accumulator 0.
- hit_Out, lives_Out, grace_Out, lose_OutLow update on the edge after the frameEnd cycle (latency 1).
- hit_Out high exactly one cycle; never in consecutive cycles unless frameEnd pulses are consecutive.
- Reset mid-frame discards accumulator and streak; reset wins over restart and frame strobes.

## Configuration
- CC_COLLISIONDETECTOR_ROWCAPTURE_EN defined: extra output CC_COLLISIONDETECTOR_hitRow_Out (RW bits) holds the lowest-index colliding row of the frame that produced the last hit; updates with hit_Out; resets to 0, unchanged by restart.
- Undefined: port and capture logic absent; all other behaviour identical.

## Structure
- Package cc_collision_pkg: state enum (PLAY, GRACE, GAMEOVER), width helper functions for RW/LW.
- Sub-module cc_collision_row_accumulator: row-hit compare, frame OR accumulator and optional lowest-row capture; parent holds FSM, streak, grace and lives counters.

## Test plan
- Defaults, 3 frames with overlap only in row 2 (frog 8'h10, backg 8'h18) -> hit_Out pulses once after 2nd frameEnd, lives 3->2, grace_Out=1; 3rd frame ignored.
- Alternating hit/no-hit frames for 10 frames -> no hit_Out, lives stay 3 (streak reset).
- After hit, 16 overlapping frames -> grace_Out drops after 16th frameEnd; 2 more overlapping frames -> second hit, lives 1.
- Drive to lives 0 -> lose_OutLow=0 sticky through further frames; restart same cycle as frameEnd -> lose_OutLow=1, lives 3, no hit.
- rowIndex=ROWS with overlap, plus frameStart/rowValid coincidence -> out-of-range row ignored, coincident row counted in new frame.
- ROWCAPTURE_EN build: overlaps in rows 5 and 3 same frame -> hitRow_Out=3 with hit_Out.

Source files
------------

// File: rtl/cc_collision_pkg.sv
// ============================================================================
// Module   : cc_collision_pkg
// Purpose  : Shared state encoding and width helpers for the collision detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cc_collision_pkg;

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_GRACE    = 2'd1,
    ST_GAMEOVER = 2'd2
  } cc_state_e;

  function automatic int cc_row_width(input int rows);
    return (rows <= 2) ? 1 : $clog2(rows);
  endfunction

  function automatic int cc_lives_width(input int lives);
    return (lives < 1) ? 1 : $clog2(lives + 1);
  endfunction

  // Width able to hold 0..n inclusive, never narrower than one bit.
  function automatic int cc_count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cc_collision_detector_if.sv
// ============================================================================
// Module   : cc_collision_detector_if
// Purpose  : Row/frame strobes and game-status bus of the collision detector.
//            Optional hitRow field when CC_COLLISIONDETECTOR_ROWCAPTURE_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cc_collision_detector_if
  import cc_collision_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8,
  parameter int LIVES     = 3
);
  localparam int RW = cc_row_width(ROWS);
  localparam int LW = cc_lives_width(LIVES);

  logic                 CC_COLLISIONDETECTOR_frameStart_In;
  logic                 CC_COLLISIONDETECTOR_frameEnd_In;
  logic                 CC_COLLISIONDETECTOR_rowValid_In;
  logic [RW-1:0]        CC_COLLISIONDETECTOR_rowIndex_In;
  logic [DATAWIDTH-1:0] CC_COLLISIONDETECTOR_backgBUS;
  logic [DATAWIDTH-1:0] CC_COLLISIONDETECTOR_froggerBUS;
  logic                 CC_COLLISIONDETECTOR_restart_In;
  logic                 CC_COLLISIONDETECTOR_lose_OutLow;
  logic                 CC_COLLISIONDETECTOR_hit_Out;
  logic [LW-1:0]        CC_COLLISIONDETECTOR_lives_Out;
  logic                 CC_COLLISIONDETECTOR_grace_Out;
`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
  logic [RW-1:0]        CC_COLLISIONDETECTOR_hitRow_Out;
`endif

  modport master (
    output CC_COLLISIONDETECTOR_frameStart_In, CC_COLLISIONDETECTOR_frameEnd_In,
    output CC_COLLISIONDETECTOR_rowValid_In, CC_COLLISIONDETECTOR_rowIndex_In,
    output CC_COLLISIONDETECTOR_backgBUS, CC_COLLISIONDETECTOR_froggerBUS,
    output CC_COLLISIONDETECTOR_restart_In,
    input  CC_COLLISIONDETECTOR_lose_OutLow, CC_COLLISIONDETECTOR_hit_Out,
    input  CC_COLLISIONDETECTOR_lives_Out, CC_COLLISIONDETECTOR_grace_Out
`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
    , input CC_COLLISIONDETECTOR_hitRow_Out
`endif
  );

  modport slave (
    input  CC_COLLISIONDETECTOR_frameStart_In, CC_COLLISIONDETECTOR_frameEnd_In,
    input  CC_COLLISIONDETECTOR_rowValid_In, CC_COLLISIONDETECTOR_rowIndex_In,
    input  CC_COLLISIONDETECTOR_backgBUS, CC_COLLISIONDETECTOR_froggerBUS,
    input  CC_COLLISIONDETECTOR_restart_In,
    output CC_COLLISIONDETECTOR_lose_OutLow, CC_COLLISIONDETECTOR_hit_Out,
    output CC_COLLISIONDETECTOR_lives_Out, CC_COLLISIONDETECTOR_grace_Out
`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
    , output CC_COLLISIONDETECTOR_hitRow_Out
`endif
  );

endinterface

`default_nettype wire

// File: rtl/cc_collision_row_accumulator.sv
// ============================================================================
// Module   : cc_collision_row_accumulator
// Purpose  : Per-row frog/background compare and per-frame OR accumulator,
//            with lowest-row tracking under CC_COLLISIONDETECTOR_ROWCAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_collision_row_accumulator
  import cc_collision_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8,
  parameter int RW        = cc_row_width(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 restart,
  input  logic                 row_valid,
  input  logic [RW-1:0]        row_index,
  input  logic [DATAWIDTH-1:0] frog_row,
  input  logic [DATAWIDTH-1:0] backg_row,
  output logic                 frame_hit
`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
  , output logic [RW-1:0]      frame_low_row
`endif
);

  localparam logic [RW:0] ROW_LIMIT = ROWS[RW:0];

  logic row_hit;
  logic prior_valid;
  logic acc_q, acc_d;

  assign row_hit = row_valid && ({1'b0, row_index} < ROW_LIMIT) && (|(frog_row & backg_row));

  // A frame-start row belongs to the new frame, so the old accumulator is masked.
  assign prior_valid = !frame_start && acc_q;

  always_comb begin
    frame_hit = prior_valid || row_hit;
    acc_d     = acc_q | row_hit;
    if (restart || (frame_start && frame_end)) begin
      acc_d = 1'b0;
    end else if (frame_start) begin
      acc_d = row_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
  logic [RW-1:0] low_q, low_d;

  // Rows may arrive in any order, so keep the minimum colliding index seen.
  always_comb begin
    frame_low_row = low_q;
    if (row_hit && (!prior_valid || (row_index < low_q))) begin
      frame_low_row = row_index;
    end
    low_d = frame_low_row;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_q <= '0;
    end else begin
      low_q <= low_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/cc_collision_detector.sv
// ============================================================================
// Module   : cc_collision_detector
// Purpose  : Frame-based frog collision arbiter: hit streak, lives, grace and
//            sticky game-over. Optional CC_COLLISIONDETECTOR_ROWCAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_collision_detector
  import cc_collision_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int ROWS         = 8,
  parameter int HIT_FRAMES   = 2,
  parameter int GRACE_FRAMES = 16,
  parameter int LIVES        = 3
) (
  input  logic                    CC_COLLISIONDETECTOR_CLOCK_50,
  input  logic                    CC_COLLISIONDETECTOR_RESET_InHigh,
  cc_collision_detector_if.slave  bus
);

  localparam int RW = cc_row_width(ROWS);
  localparam int LW = cc_lives_width(LIVES);
  localparam int SW = cc_count_width(HIT_FRAMES);
  localparam int GW = cc_count_width(GRACE_FRAMES);

  localparam logic [1:0] S_PLAY     = ST_PLAY;
  localparam logic [1:0] S_GRACE    = ST_GRACE;
  localparam logic [1:0] S_GAMEOVER = ST_GAMEOVER;

  localparam logic [SW-1:0] STREAK_LAST = SW'(HIT_FRAMES - 1);
  localparam logic [GW-1:0] GRACE_LOAD  = GW'(GRACE_FRAMES);
  localparam logic [LW-1:0] LIVES_LOAD  = LW'(LIVES);

  logic clk, rst, restart, frame_end, frame_hit;
  assign clk       = CC_COLLISIONDETECTOR_CLOCK_50;
  assign rst       = CC_COLLISIONDETECTOR_RESET_InHigh;
  assign restart   = bus.CC_COLLISIONDETECTOR_restart_In;
  assign frame_end = bus.CC_COLLISIONDETECTOR_frameEnd_In;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [GW-1:0] grace_cnt_q, grace_cnt_d;
  logic [LW-1:0] lives_q, lives_d;
  logic          hit_q, hit_d;
  logic          lose_q, lose_d;
  logic          in_grace_q, in_grace_d;

`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
  logic [RW-1:0] frame_low_row;
  logic [RW-1:0] hit_row_q, hit_row_d;
`endif

  cc_collision_row_accumulator #(
    .DATAWIDTH (DATAWIDTH),
    .ROWS      (ROWS),
    .RW        (RW)
  ) u_row_acc (
    .clk         (clk),
    .rst         (rst),
    .frame_start (bus.CC_COLLISIONDETECTOR_frameStart_In),
    .frame_end   (frame_end),
    .restart     (restart),
    .row_valid   (bus.CC_COLLISIONDETECTOR_rowValid_In),
    .row_index   (bus.CC_COLLISIONDETECTOR_rowIndex_In),
    .frog_row    (bus.CC_COLLISIONDETECTOR_froggerBUS),
    .backg_row   (bus.CC_COLLISIONDETECTOR_backgBUS),
    .frame_hit   (frame_hit)
`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
    , .frame_low_row (frame_low_row)
`endif
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    grace_cnt_d = grace_cnt_q;
    lives_d     = lives_q;
    hit_d       = 1'b0;
    if (restart) begin
      state_d     = S_PLAY;
      streak_d    = '0;
      grace_cnt_d = '0;
      lives_d     = LIVES_LOAD;
    end else if (frame_end) begin
      case (state_q)
        S_PLAY: begin
          if (!frame_hit) begin
            streak_d = '0;
          end else if (streak_q == STREAK_LAST) begin
            hit_d    = 1'b1;
            streak_d = '0;
            lives_d  = lives_q - LW'(1);
            if (lives_q == LW'(1)) begin
              state_d = S_GAMEOVER;
            end else if (GRACE_FRAMES > 0) begin
              state_d     = S_GRACE;
              grace_cnt_d = GRACE_LOAD;
            end
          end else begin
            streak_d = streak_q + SW'(1);
          end
        end
        S_GRACE: begin
          streak_d    = '0;
          grace_cnt_d = grace_cnt_q - GW'(1);
          if (grace_cnt_q == GW'(1)) begin
            state_d = S_PLAY;
          end
        end
        S_GAMEOVER: begin
          lives_d = '0;
        end
        default: begin
          state_d = S_PLAY;
        end
      endcase
    end
    lose_d     = (state_d != S_GAMEOVER);
    in_grace_d = (state_d == S_GRACE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PLAY;
      streak_q    <= '0;
      grace_cnt_q <= '0;
      lives_q     <= LIVES_LOAD;
      hit_q       <= 1'b0;
      lose_q      <= 1'b1;
      in_grace_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      grace_cnt_q <= grace_cnt_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      lose_q      <= lose_d;
      in_grace_q  <= in_grace_d;
    end
  end

  assign bus.CC_COLLISIONDETECTOR_lose_OutLow = lose_q;
  assign bus.CC_COLLISIONDETECTOR_hit_Out     = hit_q;
  assign bus.CC_COLLISIONDETECTOR_lives_Out   = lives_q;
  assign bus.CC_COLLISIONDETECTOR_grace_Out   = in_grace_q;

`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
  // Restart deliberately leaves the last captured row in place.
  always_comb begin
    hit_row_d = hit_row_q;
    if (hit_d) begin
      hit_row_d = frame_low_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_row_q <= '0;
    end else begin
      hit_row_q <= hit_row_d;
    end
  end

  assign bus.CC_COLLISIONDETECTOR_hitRow_Out = hit_row_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cc_collision_detector.sv
// ============================================================================
// Module   : tb_cc_collision_detector
// Purpose  : Self-checking bench with a queue-based game model, directed
//            scenarios and a randomized strobe phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cc_collision_detector;
  import cc_collision_pkg::*;

  localparam int DW     = 8;
  localparam int ROWS   = 6;
  localparam int HITF   = 2;
  localparam int GRACEF = 16;
  localparam int LIVES  = 3;
  localparam int RW     = cc_row_width(ROWS);

  localparam int M_PLAY = 0;
  localparam int M_GRACE = 1;
  localparam int M_OVER = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cc_collision_detector_if #(.DATAWIDTH(DW), .ROWS(ROWS), .LIVES(LIVES)) bus ();

  cc_collision_detector #(
    .DATAWIDTH(DW), .ROWS(ROWS), .HIT_FRAMES(HITF), .GRACE_FRAMES(GRACEF), .LIVES(LIVES)
  ) dut (
    .CC_COLLISIONDETECTOR_CLOCK_50     (clk),
    .CC_COLLISIONDETECTOR_RESET_InHigh (rst),
    .bus                               (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Game model: rows colliding in the open frame are kept as a list of indices.
  int m_state, m_lives, m_streak, m_grace, m_hitrow;
  int m_rows[$];
  int exp_hit;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qmin(input int q[$]);
    int m = q[0];
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  task automatic model_step(input bit fs, input bit fe, input bit rv, input int idx,
                            input logic [DW-1:0] fr, input logic [DW-1:0] bg,
                            input bit rs, input bit r);
    int cur[$];
    if (r) begin
      m_state = M_PLAY; m_lives = LIVES; m_streak = 0; m_grace = 0; m_hitrow = 0;
      m_rows.delete(); exp_hit = 0;
      return;
    end
    if (!fs) cur = m_rows;
    if (rv && idx < ROWS && (fr & bg) != 0) cur.push_back(idx);
    exp_hit = 0;
    if (rs) begin
      m_state = M_PLAY; m_lives = LIVES; m_streak = 0; m_grace = 0;
      cur.delete();
    end else if (fe) begin
      if (m_state == M_PLAY) begin
        if (cur.size() > 0) begin
          m_streak++;
          if (m_streak >= HITF) begin
            exp_hit = 1; m_streak = 0; m_lives--; m_hitrow = qmin(cur);
            if (m_lives == 0) m_state = M_OVER;
            else if (GRACEF > 0) begin m_state = M_GRACE; m_grace = GRACEF; end
          end
        end else begin
          m_streak = 0;
        end
      end else if (m_state == M_GRACE) begin
        m_grace--;
        if (m_grace == 0) m_state = M_PLAY;
      end
      if (fs) cur.delete();
    end
    m_rows = cur;
  endtask

  task automatic drive(input bit fs, input bit fe, input bit rv, input int idx,
                       input logic [DW-1:0] fr, input logic [DW-1:0] bg,
                       input bit rs, input bit r);
    int ti;
    ti = idx % (1 << RW);
    rst = r;
    bus.CC_COLLISIONDETECTOR_frameStart_In = fs;
    bus.CC_COLLISIONDETECTOR_frameEnd_In   = fe;
    bus.CC_COLLISIONDETECTOR_rowValid_In   = rv;
    bus.CC_COLLISIONDETECTOR_rowIndex_In   = ti[RW-1:0];
    bus.CC_COLLISIONDETECTOR_froggerBUS    = fr;
    bus.CC_COLLISIONDETECTOR_backgBUS      = bg;
    bus.CC_COLLISIONDETECTOR_restart_In    = rs;
    @(posedge clk);
    model_step(fs, fe, rv, ti, fr, bg, rs, r);
    #1;
  endtask

  // One full frame; ha/hb select overlapping rows (-1 = none).
  task automatic frame(input int ha, input int hb, input bit rs_end);
    for (int r = 0; r < ROWS; r++) begin
      drive(r == 0, r == ROWS - 1, 1'b1, r, (r == ha || r == hb) ? 8'h10 : 8'h01, 8'h18,
            rs_end && (r == ROWS - 1), 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("hit", int'(bus.CC_COLLISIONDETECTOR_hit_Out), exp_hit);
      check("lose", int'(bus.CC_COLLISIONDETECTOR_lose_OutLow), int'(m_state != M_OVER));
      check("lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), m_lives);
      check("grace", int'(bus.CC_COLLISIONDETECTOR_grace_Out), int'(m_state == M_GRACE));
`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
      check("hitrow", int'(bus.CC_COLLISIONDETECTOR_hitRow_Out), m_hitrow);
`endif
    end
  end

  initial begin
    bit fs, fe, rv, rs, r;
    int idx;
    logic [DW-1:0] fr, bg;

    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    chk_en = 1'b1;
    check("rst_lose", int'(bus.CC_COLLISIONDETECTOR_lose_OutLow), 1);
    check("rst_hit", int'(bus.CC_COLLISIONDETECTOR_hit_Out), 0);
    check("rst_lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), 3);
    check("rst_grace", int'(bus.CC_COLLISIONDETECTOR_grace_Out), 0);

    for (int i = 0; i < 10; i++) frame((i % 2 == 0) ? 2 : -1, -1, 0);
    check("alt_lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), 3);

    frame(2, -1, 0);
    frame(2, -1, 0);
    check("first_hit", int'(bus.CC_COLLISIONDETECTOR_hit_Out), 1);
    check("first_lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), 2);
    check("first_grace", int'(bus.CC_COLLISIONDETECTOR_grace_Out), 1);
    drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    check("hit_one_cycle", int'(bus.CC_COLLISIONDETECTOR_hit_Out), 0);
    for (int i = 0; i < 15; i++) frame(2, -1, 0);
    check("grace_15", int'(bus.CC_COLLISIONDETECTOR_grace_Out), 1);
    frame(2, -1, 0);
    check("grace_16", int'(bus.CC_COLLISIONDETECTOR_grace_Out), 0);
    frame(2, -1, 0);
    frame(2, -1, 0);
    check("second_lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), 1);

    for (int i = 0; i < GRACEF; i++) frame(-1, -1, 0);
    frame(2, -1, 0);
    frame(2, -1, 0);
    check("over_lose", int'(bus.CC_COLLISIONDETECTOR_lose_OutLow), 0);
    for (int i = 0; i < 3; i++) frame(2, -1, 0);
    check("over_sticky", int'(bus.CC_COLLISIONDETECTOR_lose_OutLow), 0);
    check("over_lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), 0);
    frame(2, -1, 1);
    check("restart_lose", int'(bus.CC_COLLISIONDETECTOR_lose_OutLow), 1);
    check("restart_lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), 3);
    check("restart_hit", int'(bus.CC_COLLISIONDETECTOR_hit_Out), 0);

    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0, 8'h01, 8'h18, 0, 0);
      drive(0, 0, 1, 6, 8'h10, 8'h18, 0, 0);
      drive(0, 0, 1, 7, 8'h10, 8'h18, 0, 0);
      drive(0, 1, 1, 1, 8'h01, 8'h18, 0, 0);
    end
    check("oob_lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), 3);
    drive(0, 0, 1, 3, 8'h10, 8'h18, 0, 0);
    frame(-1, -1, 0);
    frame(0, -1, 0);
    frame(0, -1, 0);
    check("start_row_lives", int'(bus.CC_COLLISIONDETECTOR_lives_Out), 2);
    drive(0, 0, 0, 0, 8'h00, 8'h00, 1, 0);

`ifdef CC_COLLISIONDETECTOR_ROWCAPTURE_EN
    frame(5, 3, 0);
    frame(5, 3, 0);
    check("capture_row", int'(bus.CC_COLLISIONDETECTOR_hitRow_Out), 3);
    drive(0, 0, 0, 0, 8'h00, 8'h00, 1, 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      fs  = ($urandom_range(0, 5) == 0);
      fe  = ($urandom_range(0, 5) == 0);
      rv  = $urandom_range(0, 1) != 0;
      idx = $urandom_range(0, 7);
      fr  = DW'(1) << $urandom_range(0, DW - 1);
      bg  = DW'($urandom) & DW'($urandom) & DW'($urandom);
      rs  = ($urandom_range(0, 99) == 0);
      r   = ($urandom_range(0, 299) == 0);
      drive(fs, fe, rv, idx, fr, bg, rs, r);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
